interval_timer_ctrl: RTL

Programmable interval timer controller that sequences an N-bit free-running counter datapath. It accepts a period and mode over a valid/ready configuration handshake, starts and stops the count on request, and flags each terminal count with a one-cycle `tick`. It sits between a host/config master and the counter datapath, turning a bare up-counter into a one-shot or periodic timer.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/counter_en.sv | 31 +++
 rtl/interval_timer_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types for the interval timer controller
//
// Purpose: FSM state and timer mode encodings used by interval_timer_ctrl.
// Ports: none (package).

package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } timer_mode_t;

endpackage

// File: rtl/counter_en.sv
// rtl/counter_en.sv - N-bit up-counter with synchronous clear and enable
//
// Purpose: bare counting datapath sequenced by interval_timer_ctrl.
// Ports:
//   clock   in  1  system clock
//   reset_n in  1  asynchronous active-low reset
//   clr     in  1  synchronous clear (priority over en)
//   en      in  1  increment enable
//   cnt     out N  current count

module counter_en #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] cnt
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - one-shot / periodic interval timer controller
//
// Purpose: accepts a period and mode over a valid/ready handshake, sequences
// an up-counter through IDLE/ARMED/RUN/DONE and flags each terminal count.
// Ports:
//   clock      in  1  system clock
//   reset_n    in  1  asynchronous active-low reset
//   cfg_valid  in  1  configuration offer
//   cfg_ready  out 1  configuration can be accepted (not in RUN)
//   cfg_period in  N  terminal count P; counter runs 0..P
//   cfg_mode   in  1  0 = one-shot, 1 = periodic
//   start      in  1  begin counting (level)
//   stop       in  1  abort counting (level, beats start and terminal count)
//   cnt        out N  current count
//   tick       out 1  high while running with cnt == P
//   busy       out 1  high in RUN
//   done       out 1  high in DONE

module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [N-1:0] cfg_period,
  input  logic         cfg_mode,
  input  logic         start,
  input  logic         stop,
  output logic [N-1:0] cnt,
  output logic         tick,
  output logic         busy,
  output logic         done
);

  timer_state_t state;
  timer_state_t state_nxt;
  timer_mode_t  mode_reg;
  logic [N-1:0] p_reg;
  logic         cfg_xfer;
  logic         term;
  logic         go;
  logic         cnt_clr;
  logic         cnt_en;

  assign cfg_ready = (state != RUN);
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign term      = (state == RUN) && (cnt == p_reg);
  // A start only counts when neither stop nor a configuration transfer
  // claims the same edge.
  assign go        = start && !stop && !cfg_xfer;

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_xfer) state_nxt = ARMED;
      end
      ARMED: begin
        if (go) begin
          state_nxt = RUN;
          cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = ARMED;
          cnt_clr   = 1'b1;
        end else if (term) begin
          // Periodic wraps to 0; one-shot leaves cnt parked at P.
          if (mode_reg == PERIODIC) cnt_clr = 1'b1;
          else                      state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (cfg_xfer) begin
          state_nxt = ARMED;
        end else if (go) begin
          state_nxt = RUN;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      p_reg    <= '0;
      mode_reg <= ONE_SHOT;
    end else begin
      state <= state_nxt;
      if (cfg_xfer) begin
        p_reg    <= cfg_period;
        mode_reg <= timer_mode_t'(cfg_mode);
      end
    end
  end

  counter_en #(.N(N)) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (cnt)
  );

  assign tick = term;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
